// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mmu memory port between NUM_MASTERS masters.
// Each transaction walks IDLE -> BUSY -> DONE. In BUSY the granted master's
// request fields are routed combinationally to the mmu and the mmu's ready
// pulse is routed straight back. DONE is a one-cycle gap with all mmu enables
// low so the mmu sees its enable drop between transactions.
//
// Handshake: a master raises read and/or write enable and holds the request
// fields stable until it sees a one-cycle m_mem_ready pulse on its own bit.
// Write wins if both enables are set. m_data_out is only meaningful in the
// cycle m_mem_ready is high. m_error pulses with m_mem_ready when the mmu
// failed to answer within TIMEOUT_CYCLES BUSY cycles.
module mem_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_read_enable,
    input  logic [NUM_MASTERS-1:0]            m_write_enable,
    input  logic [NUM_MASTERS-1:0]            m_signed_read,
    input  logic [2*NUM_MASTERS-1:0]          m_data_width,
    input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_address,
    input  logic [DATA_WIDTH*NUM_MASTERS-1:0] m_data_in,
    output logic [DATA_WIDTH-1:0]             m_data_out,
    output logic [NUM_MASTERS-1:0]            m_mem_ready,
    output logic [NUM_MASTERS-1:0]            m_error,
    output logic                              s_read_enable,
    output logic                              s_write_enable,
    output logic                              s_signed_read,
    output logic [1:0]                        s_data_width,
    output logic [ADDR_WIDTH-1:0]             s_address,
    output logic [DATA_WIDTH-1:0]             s_data_in,
    input  logic [DATA_WIDTH-1:0]             s_data_out,
    input  logic                              s_mem_ready,
    output logic [GW-1:0]                     grant_id,
    output logic [1:0]                        o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [GW-1:0]            r_grant;
    logic [GW-1:0]            r_last_grant;
    logic [GW-1:0]            w_winner;
    logic [GW-1:0]            w_win_hi;
    logic [GW-1:0]            w_win_lo;
    logic                     w_found_hi;
    logic                     w_found_lo;
    logic [NUM_MASTERS-1:0]   w_req;
    logic                     w_any_req;
    logic                     w_expire;

    assign w_req      = m_read_enable | m_write_enable;
    assign w_any_req  = |w_req;
    assign m_data_out = s_data_out;
    assign grant_id   = r_grant;
    assign o_state    = r_state;

    // Winner selection: fixed mode takes the lowest requester; round-robin
    // takes the first requester above last_grant, else wraps to the lowest.
    always_comb begin
        w_win_hi   = '0;
        w_win_lo   = '0;
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_req[i] && !w_found_hi && (PRIORITY_MODE == 0) && (GW'(i) > r_last_grant)) begin
                w_win_hi   = GW'(i);
                w_found_hi = 1'b1;
            end
            if (w_req[i] && !w_found_lo) begin
                w_win_lo   = GW'(i);
                w_found_lo = 1'b1;
            end
        end
        w_winner = w_found_hi ? w_win_hi : w_win_lo;
    end

    // Response timeout: counts BUSY cycles, fires on the last allowed one
    // unless the mmu answers in that same cycle.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);
            logic [CW-1:0] r_count;

            // Counter is held at zero outside BUSY, so it starts from zero on entry.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_count <= '0;
                end else if (r_state != ST_BUSY) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end

            assign w_expire = (r_state == ST_BUSY) && (r_count == LAST_COUNT) && !s_mem_ready;
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

    // State register plus grant bookkeeping, updated when a grant is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_any_req) begin
                r_grant      <= w_winner;
                r_last_grant <= w_winner;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_next_state = ST_BUSY;
            ST_BUSY: if (s_mem_ready || w_expire) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath mux: route the granted master to the mmu while BUSY and
    // return the completion/error pulse to that master only.
    always_comb begin
        s_read_enable  = 1'b0;
        s_write_enable = 1'b0;
        s_signed_read  = 1'b0;
        s_data_width   = 2'b00;
        s_address      = '0;
        s_data_in      = '0;
        m_mem_ready    = '0;
        m_error        = '0;
        if (r_state == ST_BUSY) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (r_grant == GW'(i)) begin
                    s_write_enable = m_write_enable[i];
                    s_read_enable  = m_read_enable[i] & ~m_write_enable[i];
                    s_signed_read  = m_signed_read[i];
                    s_data_width   = m_data_width[i*2 +: 2];
                    s_address      = m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                    s_data_in      = m_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                    m_mem_ready[i] = s_mem_ready | w_expire;
                    m_error[i]     = w_expire;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance A is 3 masters, round-robin, timeout 8;
// instance B is 2 masters, fixed priority, no timeout. A small mmu model per
// instance answers after a programmable latency; completions are checked
// against an expected queue filled when stimulus is set up.
module tb_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- instance A signals ----------------
    logic [2:0]  a_re = '0, a_we = '0, a_sr = '0;
    logic [5:0]  a_dw = '0;
    logic [95:0] a_addr = '0, a_din = '0;
    logic [31:0] a_dout;
    logic [2:0]  a_rdy, a_err;
    logic        a_sre, a_swe, a_ssr;
    logic [1:0]  a_sdw;
    logic [31:0] a_saddr, a_sdin;
    logic [31:0] a_sdo = '0;
    logic        a_smr = 1'b0;
    logic [1:0]  a_gid;
    logic [1:0]  a_st;

    // ---------------- instance B signals ----------------
    logic [1:0]  b_re = '0, b_we = '0, b_sr = '0;
    logic [3:0]  b_dw = '0;
    logic [63:0] b_addr = '0, b_din = '0;
    logic [31:0] b_dout;
    logic [1:0]  b_rdy, b_err;
    logic        b_sre, b_swe, b_ssr;
    logic [1:0]  b_sdw;
    logic [31:0] b_saddr, b_sdin;
    logic [31:0] b_sdo = '0;
    logic        b_smr = 1'b0;
    logic [0:0]  b_gid;
    logic [1:0]  b_st;

    mem_arbiter #(
        .NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)
    ) u_a (
        .clk(clk), .reset(reset),
        .m_read_enable(a_re), .m_write_enable(a_we), .m_signed_read(a_sr),
        .m_data_width(a_dw), .m_address(a_addr), .m_data_in(a_din),
        .m_data_out(a_dout), .m_mem_ready(a_rdy), .m_error(a_err),
        .s_read_enable(a_sre), .s_write_enable(a_swe), .s_signed_read(a_ssr),
        .s_data_width(a_sdw), .s_address(a_saddr), .s_data_in(a_sdin),
        .s_data_out(a_sdo), .s_mem_ready(a_smr),
        .grant_id(a_gid), .o_state(a_st)
    );

    mem_arbiter #(
        .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)
    ) u_b (
        .clk(clk), .reset(reset),
        .m_read_enable(b_re), .m_write_enable(b_we), .m_signed_read(b_sr),
        .m_data_width(b_dw), .m_address(b_addr), .m_data_in(b_din),
        .m_data_out(b_dout), .m_mem_ready(b_rdy), .m_error(b_err),
        .s_read_enable(b_sre), .s_write_enable(b_swe), .s_signed_read(b_ssr),
        .s_data_width(b_sdw), .s_address(b_saddr), .s_data_in(b_sdin),
        .s_data_out(b_sdo), .s_mem_ready(b_smr),
        .grant_id(b_gid), .o_state(b_st)
    );

    // ---------------- mmu models ----------------
    function automatic logic [31:0] data_of(input logic [31:0] addr);
        return (addr == 32'h100) ? 32'hDEADBEEF : ((addr ^ 32'hC0DE0000) + 32'd7);
    endfunction

    int lat_a = 3, lat_b = 2;
    bit hang_a = 1'b0;
    int cnt_a = 0, cnt_b = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                cnt_a = 0;
                a_smr = 1'b0;
            end else if ((a_sre || a_swe) && !a_smr) begin
                cnt_a++;
                if (!hang_a && cnt_a >= lat_a) begin
                    a_smr = 1'b1;
                    a_sdo = data_of(a_saddr);
                end
            end else begin
                cnt_a = 0;
                a_smr = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                cnt_b = 0;
                b_smr = 1'b0;
            end else if ((b_sre || b_swe) && !b_smr) begin
                cnt_b++;
                if (cnt_b >= lat_b) begin
                    b_smr = 1'b1;
                    b_sdo = data_of(b_saddr);
                end
            end else begin
                cnt_b = 0;
                b_smr = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [37:0] exp_a_q[$];
    logic [35:0] exp_b_q[$];
    logic [37:0] mon_e_a;
    logic [35:0] mon_e_b;

    function automatic void push_a(input int g, input bit err, input logic [31:0] d);
        logic [2:0] oh;
        oh = 3'b001 << g;
        exp_a_q.push_back({(err ? oh : 3'b000), oh, d});
    endfunction

    function automatic void push_b(input int g, input logic [31:0] d);
        logic [1:0] oh;
        oh = 2'b01 << g;
        exp_b_q.push_back({2'b00, oh, d});
    endfunction

    // Every completion or error pulse must match the next expected entry.
    always @(negedge clk) begin
        if (a_rdy != 3'b000 || a_err != 3'b000) begin
            n_vec++;
            if (exp_a_q.size() == 0) begin
                $display("FAIL sb_a_unexpected: err=%b rdy=%b data=%h, required no pulse", a_err, a_rdy, a_dout);
                n_err++;
            end else begin
                mon_e_a = exp_a_q.pop_front();
                if ({a_err, a_rdy, a_dout} !== mon_e_a) begin
                    $display("FAIL sb_a: err=%b rdy=%b data=%h, required err=%b rdy=%b data=%h",
                             a_err, a_rdy, a_dout, mon_e_a[37:35], mon_e_a[34:32], mon_e_a[31:0]);
                    n_err++;
                end
            end
        end
        if (b_rdy != 2'b00 || b_err != 2'b00) begin
            n_vec++;
            if (exp_b_q.size() == 0) begin
                $display("FAIL sb_b_unexpected: err=%b rdy=%b data=%h, required no pulse", b_err, b_rdy, b_dout);
                n_err++;
            end else begin
                mon_e_b = exp_b_q.pop_front();
                if ({b_err, b_rdy, b_dout} !== mon_e_b) begin
                    $display("FAIL sb_b: err=%b rdy=%b data=%h, required err=%b rdy=%b data=%h",
                             b_err, b_rdy, b_dout, mon_e_b[35:34], mon_e_b[33:32], mon_e_b[31:0]);
                    n_err++;
                end
            end
        end
    end

    // ---------------- master models / drivers ----------------
    bit          mrd_a[3], mwr_a[3], msr_a[3];
    logic [1:0]  mdw_a[3];
    logic [31:0] maddr_a[3], mdat_a[3];
    int          left_a[3];
    bit          mrd_b[2];
    logic [31:0] maddr_b[2];
    int          left_b[2];

    task automatic set_master_a(input int i, input bit rd, input bit wr, input bit sr,
                                input logic [1:0] dw, input logic [31:0] addr,
                                input logic [31:0] wdata, input int cnt);
        mrd_a[i] = rd; mwr_a[i] = wr; msr_a[i] = sr; mdw_a[i] = dw;
        maddr_a[i] = addr; mdat_a[i] = wdata; left_a[i] = cnt;
    endtask

    task automatic set_master_b(input int i, input logic [31:0] addr, input int cnt);
        mrd_b[i] = 1'b1; maddr_b[i] = addr; left_b[i] = cnt;
    endtask

    task automatic apply_a();
        for (int i = 0; i < 3; i++) begin
            a_re[i] = mrd_a[i] && (left_a[i] > 0);
            a_we[i] = mwr_a[i] && (left_a[i] > 0);
            a_sr[i] = msr_a[i];
            a_dw[i*2 +: 2]   = mdw_a[i];
            a_addr[i*32 +: 32] = maddr_a[i];
            a_din[i*32 +: 32]  = mdat_a[i];
        end
    endtask

    task automatic apply_b();
        for (int i = 0; i < 2; i++) begin
            b_re[i] = mrd_b[i] && (left_b[i] > 0);
            b_addr[i*32 +: 32] = maddr_b[i];
        end
    endtask

    // Runs A's masters until each has seen its requested number of completions.
    task automatic run_a(input int budget, input bit chk_gap);
        int  cyc;
        bit  have_prev;
        time t_prev;
        cyc = 0; have_prev = 1'b0; t_prev = 0;
        while ((left_a[0] + left_a[1] + left_a[2]) > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (a_st == 2'd2) begin
                n_vec++;
                if (a_sre !== 1'b0 || a_swe !== 1'b0) begin
                    $display("FAIL done_enables_a: re=%b we=%b, required 0 0", a_sre, a_swe);
                    n_err++;
                end
            end
            if (a_rdy != 3'b000) begin
                if (chk_gap && have_prev) begin
                    n_vec++;
                    if (($time - t_prev) != time'((lat_a + 2) * 10)) begin
                        $display("FAIL throughput_a: gap=%0t, required %0d", $time - t_prev, (lat_a + 2) * 10);
                        n_err++;
                    end
                end
                have_prev = 1'b1;
                t_prev = $time;
            end
            for (int i = 0; i < 3; i++) if (a_rdy[i] && left_a[i] > 0) left_a[i]--;
            @(posedge clk);
            #1;
            apply_a();
        end
        if ((left_a[0] + left_a[1] + left_a[2]) > 0) begin
            n_vec++; n_err++;
            $display("FAIL run_a_timeout: left=%0d/%0d/%0d, required 0/0/0", left_a[0], left_a[1], left_a[2]);
            for (int i = 0; i < 3; i++) left_a[i] = 0;
            apply_a();
        end
    endtask

    task automatic run_b(input int budget);
        int cyc;
        cyc = 0;
        while ((left_b[0] + left_b[1]) > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) if (b_rdy[i] && left_b[i] > 0) left_b[i]--;
            @(posedge clk);
            #1;
            apply_b();
        end
        if ((left_b[0] + left_b[1]) > 0) begin
            n_vec++; n_err++;
            $display("FAIL run_b_timeout: left=%0d/%0d, required 0/0", left_b[0], left_b[1]);
            left_b[0] = 0; left_b[1] = 0;
            apply_b();
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) left_a[i] = 0;
        left_b[0] = 0; left_b[1] = 0;
        apply_a(); apply_b();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        a_re = 3'b011; a_we = 3'b100; a_sr = 3'b111; a_dw = 6'h3F;
        a_addr = {3{32'h0000_1234}}; a_din = {3{32'hFFFF_0000}};
        a_sdo = 32'h1234_5678; b_re = 2'b11;
        #1;
        n_vec++;
        if ({a_sre, a_swe, a_ssr, a_sdw, a_rdy, a_err} !== 11'b0) begin
            $display("FAIL reset_ctrl_a: re=%b we=%b sr=%b dw=%b rdy=%b err=%b, required all 0",
                     a_sre, a_swe, a_ssr, a_sdw, a_rdy, a_err);
            n_err++;
        end
        n_vec++;
        if (a_saddr !== 32'h0 || a_sdin !== 32'h0) begin
            $display("FAIL reset_bus_a: addr=%h din=%h, required 0 0", a_saddr, a_sdin);
            n_err++;
        end
        n_vec++;
        if (a_gid !== 2'd0 || a_st !== 2'd0) begin
            $display("FAIL reset_state_a: gid=%0d st=%0d, required 0 0", a_gid, a_st);
            n_err++;
        end
        n_vec++;
        if (a_dout !== 32'h1234_5678) begin
            $display("FAIL reset_dout_passthru: got %h, required 12345678", a_dout);
            n_err++;
        end
        n_vec++;
        if (b_sre !== 1'b0 || b_gid !== 1'b0 || b_rdy !== 2'b00) begin
            $display("FAIL reset_b: re=%b gid=%b rdy=%b, required 0 0 00", b_sre, b_gid, b_rdy);
            n_err++;
        end
        a_re = '0; a_we = '0; a_sr = '0; a_dw = '0; a_addr = '0; a_din = '0; b_re = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        lat_a = 3;
        set_master_a(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 1);
        push_a(0, 1'b0, 32'hDEADBEEF);
        @(posedge clk); #1; apply_a();
        @(negedge clk);
        n_vec++;
        if (a_st !== 2'd0 || a_sre !== 1'b0) begin
            $display("FAIL single_idle: st=%0d re=%b, required 0 0", a_st, a_sre);
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (a_sre !== 1'b1 || a_saddr !== 32'h100 || a_gid !== 2'd0) begin
            $display("FAIL single_busy: re=%b addr=%h gid=%0d, required 1 00000100 0", a_sre, a_saddr, a_gid);
            n_err++;
        end
        run_a(20, 1'b0);
        @(negedge clk);
        n_vec++;
        if (a_st !== 2'd2 || a_sre !== 1'b0) begin
            $display("FAIL single_done: st=%0d re=%b, required 2 0", a_st, a_sre);
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (a_st !== 2'd0) begin
            $display("FAIL single_back_idle: st=%0d, required 0", a_st);
            n_err++;
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        lat_a = 2;
        set_master_a(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 2);
        set_master_a(1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h20, 32'h1111_2222, 2);
        push_a(0, 1'b0, data_of(32'h10));
        push_a(1, 1'b0, data_of(32'h20));
        push_a(0, 1'b0, data_of(32'h10));
        push_a(1, 1'b0, data_of(32'h20));
        @(posedge clk); #1; apply_a();
        run_a(80, 1'b1);
    endtask

    task automatic test_fixed_priority();
        do_reset();
        lat_b = 2;
        set_master_b(0, 32'h40, 3);
        set_master_b(1, 32'h50, 1);
        push_b(0, data_of(32'h40));
        push_b(0, data_of(32'h40));
        push_b(0, data_of(32'h40));
        push_b(1, data_of(32'h50));
        @(posedge clk); #1; apply_b();
        run_b(80);
    endtask

    task automatic test_wrap();
        lat_a = 2;
        set_master_a(2, 1'b1, 1'b0, 1'b0, 2'd2, 32'h70, 32'h0, 1);
        push_a(2, 1'b0, data_of(32'h70));
        @(posedge clk); #1; apply_a();
        run_a(30, 1'b0);
        n_vec++;
        if (a_gid !== 2'd2) begin
            $display("FAIL wrap_last_grant: gid=%0d, required 2", a_gid);
            n_err++;
        end
        set_master_a(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h60, 32'h0, 1);
        set_master_a(2, 1'b1, 1'b0, 1'b0, 2'd2, 32'h70, 32'h0, 1);
        push_a(0, 1'b0, data_of(32'h60));
        push_a(2, 1'b0, data_of(32'h70));
        @(posedge clk); #1; apply_a();
        run_a(40, 1'b0);
    endtask

    task automatic test_timeout();
        int busy_n;
        bit seen;
        hang_a = 1'b1;
        set_master_a(1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h80, 32'h0, 1);
        push_a(1, 1'b1, a_sdo);
        @(posedge clk); #1; apply_a();
        busy_n = 0; seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (a_st == 2'd1) busy_n++;
            if (a_rdy[1]) seen = 1'b1;
        end
        n_vec++;
        if (!seen || busy_n != 8) begin
            $display("FAIL timeout_cycle: seen=%b busy_cycles=%0d, required 1 8", seen, busy_n);
            n_err++;
        end
        left_a[1] = 0;
        @(posedge clk); #1; apply_a();
        hang_a = 1'b0;
        // mmu answers in exactly the cycle the timeout would fire.
        lat_a = 8;
        set_master_a(1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h90, 32'h0, 1);
        push_a(1, 1'b0, data_of(32'h90));
        @(posedge clk); #1; apply_a();
        run_a(30, 1'b0);
    endtask

    task automatic test_reset_mid_busy();
        lat_a = 3;
        set_master_a(1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h30, 32'h0, 1);
        @(posedge clk); #1; apply_a();
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (a_st !== 2'd1 || a_gid !== 2'd1 || a_sre !== 1'b1) begin
            $display("FAIL rst_pre_busy: st=%0d gid=%0d re=%b, required 1 1 1", a_st, a_gid, a_sre);
            n_err++;
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (a_sre !== 1'b0 || a_st !== 2'd0 || a_gid !== 2'd0) begin
            $display("FAIL rst_async: re=%b st=%0d gid=%0d, required 0 0 0", a_sre, a_st, a_gid);
            n_err++;
        end
        set_master_a(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h40, 32'h0, 1);
        push_a(0, 1'b0, data_of(32'h40));
        push_a(1, 1'b0, data_of(32'h30));
        apply_a();
        @(negedge clk);
        reset = 1'b0;
        run_a(60, 1'b0);
    endtask

    task automatic test_write_path();
        lat_a = 4;
        set_master_a(1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h2000, 32'hA5A5A5A5, 1);
        push_a(1, 1'b0, data_of(32'h2000));
        @(posedge clk); #1; apply_a();
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (a_swe !== 1'b1 || a_sre !== 1'b0 || a_saddr !== 32'h2000 ||
                a_sdin !== 32'hA5A5A5A5 || a_sdw !== 2'd2) begin
                $display("FAIL write_path: we=%b re=%b addr=%h din=%h dw=%0d, required 1 0 00002000 a5a5a5a5 2",
                         a_swe, a_sre, a_saddr, a_sdin, a_sdw);
                n_err++;
            end
        end
        run_a(20, 1'b0);
        // Both enables set: write wins, sign flag and width pass through.
        lat_a = 2;
        set_master_a(2, 1'b1, 1'b1, 1'b1, 2'd1, 32'h3000, 32'h0F0F0F0F, 1);
        push_a(2, 1'b0, data_of(32'h3000));
        @(posedge clk); #1; apply_a();
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (a_swe !== 1'b1 || a_sre !== 1'b0 || a_ssr !== 1'b1 || a_sdw !== 2'd1 || a_saddr !== 32'h3000) begin
            $display("FAIL write_precedence: we=%b re=%b sr=%b dw=%0d addr=%h, required 1 0 1 1 00003000",
                     a_swe, a_sre, a_ssr, a_sdw, a_saddr);
            n_err++;
        end
        run_a(20, 1'b0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 3; i++) set_master_a(i, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 2; i++) begin
            mrd_b[i] = 1'b0; maddr_b[i] = '0; left_b[i] = 0;
        end
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_wrap();
        test_timeout();
        test_reset_mid_busy();
        test_write_path();
        repeat (4) @(negedge clk);
        n_vec++;
        if (exp_a_q.size() != 0) begin
            $display("FAIL sb_a_leftover: %0d pending, required 0", exp_a_q.size());
            n_err++;
        end
        n_vec++;
        if (exp_b_q.size() != 0) begin
            $display("FAIL sb_b_leftover: %0d pending, required 0", exp_b_q.size());
            n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
